ec_point_unit: RTL and testbench

Sequential, parametrised elliptic-curve point adder/doubler for short-Weierstrass curves with a = 0 (y² = x³ + b) over prime field GF(P), affine coordinates. A single shared bit-serial modular multiplier and a one-cycle add/sub unit are driven by an internal micro-sequencer; inversion is by Fermat (z^(P−2)). The block handles point-at-infinity and equal/opposite-point cases in hardware and sits beneath the scalar-multiplication controller as its group-operation engine.

---
 rtl/ec_point_unit_if.sv | 31 +++
 rtl/ec_point_unit.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_ec_point_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ec_point_unit_if.sv
// ec_point_unit_if: request/response bundle for the elliptic-curve point unit.
// master = requester (scalar-multiplication controller), slave = ec_point_unit.
interface ec_point_unit_if #(
   parameter int WIDTH = 256
);
   logic             start;
   logic             op_dbl;
   logic [WIDTH-1:0] x1;
   logic [WIDTH-1:0] y1;
   logic [WIDTH-1:0] x2;
   logic [WIDTH-1:0] y2;
   logic             inf1;
   logic             inf2;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] x3;
   logic [WIDTH-1:0] y3;
   logic             inf3;
   logic             err;

   modport master (
      output start, op_dbl, x1, y1, x2, y2, inf1, inf2,
      input  ready, busy, done, x3, y3, inf3, err
   );

   modport slave (
      input  start, op_dbl, x1, y1, x2, y2, inf1, inf2,
      output ready, busy, done, x3, y3, inf3, err
   );
endinterface

// File: rtl/ec_point_unit.sv
// ec_point_unit: affine point add/double on y^2 = x^3 + b over GF(P).
// One bit-serial modular multiplier and a one-cycle add/sub unit are driven by
// a micro-op ROM; inversion is d^(P-2) by square-and-multiply.
// Optional feature macro: EC_DOUBLE_EN (doubling datapath; without it doubling
// requests finish immediately with err = 1).
module ec_point_unit #(
   parameter int             WIDTH = 256,
   parameter logic [WIDTH-1:0] P   = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
   input  logic          clk,
   input  logic          rst,
   ec_point_unit_if.slave bus
);
   localparam int               CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] E  = P - WIDTH'(2);
   localparam logic [CW-1:0]    CNT_TOP = CW'(WIDTH - 1);

   // register-file slots
   localparam logic [3:0] R_X1 = 4'd0,  R_Y1 = 4'd1,  R_X2 = 4'd2,  R_Y2 = 4'd3;
   localparam logic [3:0] R_N  = 4'd4,  R_D  = 4'd5,  R_I  = 4'd6,  R_L  = 4'd7;
   localparam logic [3:0] R_S  = 4'd8,  R_R  = 4'd9,  R_X3 = 4'd10, R_T  = 4'd11;
   localparam logic [3:0] R_U  = 4'd12, R_Y3 = 4'd13;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CHECK = 2'd1, S_RUN = 2'd2, S_FIN = 2'd3} state_e;
   typedef enum logic [1:0] {U_ADD = 2'd0, U_SUB = 2'd1, U_MUL = 2'd2, U_INV = 2'd3} uop_e;
   typedef struct packed {
      uop_e       op;
      logic [3:0] dst;
      logic [3:0] a;
      logic [3:0] b;
      logic       last;
   } uop_t;

   function automatic uop_t mk(input uop_e op, input logic [3:0] dst, input logic [3:0] a,
                               input logic [3:0] b, input logic last);
      uop_t u;
      u.op = op; u.dst = dst; u.a = a; u.b = b; u.last = last;
      return u;
   endfunction

   // add program at 0..9, doubling program at 10..21
   function automatic uop_t uop_rom(input logic [4:0] pc);
      uop_t u;
      case (pc)
         5'd0:  u = mk(U_SUB, R_N,  R_Y2, R_Y1, 1'b0);
         5'd1:  u = mk(U_SUB, R_D,  R_X2, R_X1, 1'b0);
         5'd2:  u = mk(U_INV, R_I,  R_D,  R_D,  1'b0);
         5'd3:  u = mk(U_MUL, R_L,  R_N,  R_I,  1'b0);
         5'd4:  u = mk(U_MUL, R_S,  R_L,  R_L,  1'b0);
         5'd5:  u = mk(U_SUB, R_R,  R_S,  R_X1, 1'b0);
         5'd6:  u = mk(U_SUB, R_X3, R_R,  R_X2, 1'b0);
         5'd7:  u = mk(U_SUB, R_T,  R_X1, R_X3, 1'b0);
         5'd8:  u = mk(U_MUL, R_U,  R_L,  R_T,  1'b0);
         5'd9:  u = mk(U_SUB, R_Y3, R_U,  R_Y1, 1'b1);
`ifdef EC_DOUBLE_EN
         5'd10: u = mk(U_MUL, R_S,  R_X1, R_X1, 1'b0);
         5'd11: u = mk(U_ADD, R_N,  R_S,  R_S,  1'b0);
         5'd12: u = mk(U_ADD, R_N,  R_N,  R_S,  1'b0);
         5'd13: u = mk(U_ADD, R_D,  R_Y1, R_Y1, 1'b0);
         5'd14: u = mk(U_INV, R_I,  R_D,  R_D,  1'b0);
         5'd15: u = mk(U_MUL, R_L,  R_N,  R_I,  1'b0);
         5'd16: u = mk(U_MUL, R_S,  R_L,  R_L,  1'b0);
         5'd17: u = mk(U_SUB, R_R,  R_S,  R_X1, 1'b0);
         5'd18: u = mk(U_SUB, R_X3, R_R,  R_X1, 1'b0);
         5'd19: u = mk(U_SUB, R_T,  R_X1, R_X3, 1'b0);
         5'd20: u = mk(U_MUL, R_U,  R_L,  R_T,  1'b0);
         5'd21: u = mk(U_SUB, R_Y3, R_U,  R_Y1, 1'b1);
`endif
         default: u = mk(U_ADD, R_U, R_U, R_U, 1'b1);
      endcase
      return u;
   endfunction

   function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, P}) s = s - {1'b0, P};
      else                s = s;
      return s[WIDTH-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      s = {1'b0, a} - {1'b0, b};
      if (s[WIDTH]) s = s + {1'b0, P};
      else          s = s;
      return s[WIDTH-1:0];
   endfunction

   // one interleaved step: 2*acc + bit*a, brought back below P
   function automatic logic [WIDTH-1:0] mul_step(input logic [WIDTH-1:0] acc, input logic [WIDTH-1:0] a,
                                                 input logic bit_k);
      logic [WIDTH+1:0] t;
      t = {1'b0, acc, 1'b0};
      if (bit_k) t = t + {2'b00, a};
      else       t = t;
      if (t >= {2'b00, P}) t = t - {2'b00, P};
      else                 t = t;
      if (t >= {2'b00, P}) t = t - {2'b00, P};
      else                 t = t;
      return t[WIDTH-1:0];
   endfunction

   state_e           state_r, state_nx_s;
   logic [WIDTH-1:0] rf_r [0:15];
   logic             op_dbl_r, inf1_r, inf2_r, inf_r, err_r;
   logic [4:0]       pc_r;
   logic [CW-1:0]    cnt_r, ebit_r;
   logic             phase_r;   // inversion: 0 = squaring, 1 = multiply by d
   logic [WIDTH-1:0] mul_acc_r, inv_acc_r;

   uop_t             uop_s;
   logic [WIDTH-1:0] opa_s, opb_s, mul_a_s, mul_b_s, mul_nx_s, alu_s;
   logic             mul_last_s, step_done_s;
   logic             chk_special_s, chk_inf_s, chk_err_s, chk_dbl_s;
   logic [WIDTH-1:0] chk_x_s, chk_y_s;

   assign bus.ready = (state_r == S_IDLE);
   assign bus.busy  = (state_r != S_IDLE);

   // datapath decode: operand muxing, arithmetic results, micro-op completion
   always_comb begin
      uop_s      = uop_rom(pc_r);
      opa_s      = rf_r[uop_s.a];
      opb_s      = rf_r[uop_s.b];
      mul_a_s    = opa_s;
      mul_b_s    = opb_s;
      if (uop_s.op == U_INV) begin
         mul_a_s = inv_acc_r;
         mul_b_s = phase_r ? opa_s : inv_acc_r;
      end else begin
         mul_a_s = opa_s;
         mul_b_s = opb_s;
      end
      mul_nx_s   = mul_step(mul_acc_r, mul_a_s, mul_b_s[cnt_r]);
      alu_s      = (uop_s.op == U_ADD) ? mod_add(opa_s, opb_s) : mod_sub(opa_s, opb_s);
      mul_last_s = (cnt_r == {CW{1'b0}});
      case (uop_s.op)
         U_ADD, U_SUB: step_done_s = 1'b1;
         U_MUL:        step_done_s = mul_last_s;
         U_INV:        step_done_s = mul_last_s && (ebit_r == {CW{1'b0}}) && (phase_r || !E[ebit_r]);
         default:      step_done_s = 1'b0;
      endcase
   end

   // special-case classification of the captured operands
   always_comb begin
      chk_special_s = 1'b0;
      chk_inf_s     = 1'b0;
      chk_err_s     = 1'b0;
      chk_dbl_s     = 1'b0;
      chk_x_s       = {WIDTH{1'b0}};
      chk_y_s       = {WIDTH{1'b0}};
      if (!op_dbl_r) begin
         if (inf1_r) begin
            chk_special_s = 1'b1;
            chk_inf_s     = inf2_r;
            if (inf2_r) begin
               chk_x_s = {WIDTH{1'b0}};
               chk_y_s = {WIDTH{1'b0}};
            end else begin
               chk_x_s = rf_r[R_X2];
               chk_y_s = rf_r[R_Y2];
            end
         end else if (inf2_r) begin
            chk_special_s = 1'b1;
            chk_x_s       = rf_r[R_X1];
            chk_y_s       = rf_r[R_Y1];
         end else if ((rf_r[R_X1] == rf_r[R_X2]) && (rf_r[R_Y1] != rf_r[R_Y2])) begin
            chk_special_s = 1'b1;
            chk_inf_s     = 1'b1;
         end else if (rf_r[R_X1] == rf_r[R_X2]) begin
`ifdef EC_DOUBLE_EN
            chk_dbl_s     = 1'b1;
`else
            chk_special_s = 1'b1;
            chk_inf_s     = 1'b1;
            chk_err_s     = 1'b1;
`endif
         end else begin
            chk_dbl_s = 1'b0;
         end
      end else begin
`ifdef EC_DOUBLE_EN
         if (inf1_r || (rf_r[R_Y1] == {WIDTH{1'b0}})) begin
            chk_special_s = 1'b1;
            chk_inf_s     = 1'b1;
         end else begin
            chk_dbl_s = 1'b1;
         end
`else
         chk_special_s = 1'b1;
         chk_inf_s     = 1'b1;
         chk_err_s     = 1'b1;
`endif
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_r <= S_IDLE;
      else     state_r <= state_nx_s;
   end

   // next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         S_IDLE:  if (bus.start) state_nx_s = S_CHECK; else state_nx_s = S_IDLE;
         S_CHECK: if (chk_special_s) state_nx_s = S_FIN; else state_nx_s = S_RUN;
         S_RUN:   if (step_done_s && uop_s.last) state_nx_s = S_FIN; else state_nx_s = S_RUN;
         S_FIN:   state_nx_s = S_IDLE;
         default: state_nx_s = S_IDLE;
      endcase
   end

   // operand capture, micro-op execution and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 16; k++) rf_r[k] <= {WIDTH{1'b0}};
         op_dbl_r  <= 1'b0;
         inf1_r    <= 1'b0;
         inf2_r    <= 1'b0;
         inf_r     <= 1'b0;
         err_r     <= 1'b0;
         pc_r      <= 5'd0;
         cnt_r     <= CNT_TOP;
         ebit_r    <= CNT_TOP;
         phase_r   <= 1'b0;
         mul_acc_r <= {WIDTH{1'b0}};
         inv_acc_r <= {{(WIDTH-1){1'b0}}, 1'b1};
         bus.done  <= 1'b0;
         bus.x3    <= {WIDTH{1'b0}};
         bus.y3    <= {WIDTH{1'b0}};
         bus.inf3  <= 1'b0;
         bus.err   <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (bus.start) begin
                  rf_r[R_X1] <= bus.x1;
                  rf_r[R_Y1] <= bus.y1;
                  rf_r[R_X2] <= bus.x2;
                  rf_r[R_Y2] <= bus.y2;
                  op_dbl_r   <= bus.op_dbl;
                  inf1_r     <= bus.inf1;
                  inf2_r     <= bus.inf2;
               end
            end
            S_CHECK: begin
               rf_r[R_X3] <= chk_x_s;
               rf_r[R_Y3] <= chk_y_s;
               inf_r      <= chk_inf_s;
               err_r      <= chk_err_s;
               pc_r       <= chk_dbl_s ? 5'd10 : 5'd0;
               cnt_r      <= CNT_TOP;
               ebit_r     <= CNT_TOP;
               phase_r    <= 1'b0;
               mul_acc_r  <= {WIDTH{1'b0}};
               inv_acc_r  <= {{(WIDTH-1){1'b0}}, 1'b1};
            end
            S_RUN: begin
               if (step_done_s) begin
                  rf_r[uop_s.dst] <= ((uop_s.op == U_ADD) || (uop_s.op == U_SUB)) ? alu_s : mul_nx_s;
                  pc_r      <= pc_r + 5'd1;
                  cnt_r     <= CNT_TOP;
                  ebit_r    <= CNT_TOP;
                  phase_r   <= 1'b0;
                  mul_acc_r <= {WIDTH{1'b0}};
                  inv_acc_r <= {{(WIDTH-1){1'b0}}, 1'b1};
               end else if (mul_last_s) begin
                  // inversion: one square/multiply finished, pick the next one
                  inv_acc_r <= mul_nx_s;
                  mul_acc_r <= {WIDTH{1'b0}};
                  cnt_r     <= CNT_TOP;
                  if (!phase_r && E[ebit_r]) begin
                     phase_r <= 1'b1;
                  end else begin
                     phase_r <= 1'b0;
                     ebit_r  <= ebit_r - CW'(1);
                  end
               end else begin
                  mul_acc_r <= mul_nx_s;
                  cnt_r     <= cnt_r - CW'(1);
               end
            end
            S_FIN: begin
               bus.done <= 1'b1;
               bus.x3   <= rf_r[R_X3];
               bus.y3   <= rf_r[R_Y3];
               bus.inf3 <= inf_r;
               bus.err  <= err_r;
            end
            default: begin
               bus.done <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ec_point_unit.sv
// tb_ec_point_unit: directed tests of ec_point_unit on GF(17), y^2 = x^3 + 7.
module tb_ec_point_unit;
   localparam int LADD = 68;
   localparam int LSP  = 2;
`ifdef EC_DOUBLE_EN
   localparam int         DBL_LAT = 74;
   localparam logic [4:0] DBL_X   = 5'd12;
   localparam logic [4:0] DBL_Y   = 5'd16;
   localparam logic       DBL_INF = 1'b0;
   localparam logic       DBL_ERR = 1'b0;
`else
   localparam int         DBL_LAT = 2;
   localparam logic [4:0] DBL_X   = 5'd0;
   localparam logic [4:0] DBL_Y   = 5'd0;
   localparam logic       DBL_INF = 1'b1;
   localparam logic       DBL_ERR = 1'b1;
`endif

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   ec_point_unit_if #(.WIDTH(5)) bus ();

   ec_point_unit #(.WIDTH(5), .P(5'd17)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic issue(input logic dbl, input logic i1, input logic [4:0] ax, input logic [4:0] ay,
                        input logic i2, input logic [4:0] bx, input logic [4:0] by);
      bus.op_dbl = dbl; bus.inf1 = i1; bus.x1 = ax; bus.y1 = ay;
      bus.inf2 = i2; bus.x2 = bx; bus.y2 = by;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int k = 1; k <= 400; k++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset;
      n_checks += 7;
      if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", bus.ready); end
      if (bus.busy  !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", bus.busy); end
      if (bus.done  !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", bus.done); end
      if (bus.x3 !== 5'd0) begin n_fail++; $display("FAIL rst_x3 got %0d want 0", bus.x3); end
      if (bus.y3 !== 5'd0) begin n_fail++; $display("FAIL rst_y3 got %0d want 0", bus.y3); end
      if (bus.inf3 !== 1'b0) begin n_fail++; $display("FAIL rst_inf3 got %b want 0", bus.inf3); end
      if (bus.err  !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", bus.err); end
   endtask

   task automatic test_add;
      int lat;
      @(negedge clk);
      issue(1'b0, 1'b0, 5'd1, 5'd5, 1'b0, 5'd2, 5'd7);
      wait_done(lat);
      n_checks += 7;
      if (lat !== LADD) begin n_fail++; $display("FAIL add_lat got %0d want %0d", lat, LADD); end
      if (bus.x3 !== 5'd1)  begin n_fail++; $display("FAIL add_x3 got %0d want 1", bus.x3); end
      if (bus.y3 !== 5'd12) begin n_fail++; $display("FAIL add_y3 got %0d want 12", bus.y3); end
      if (bus.inf3 !== 1'b0) begin n_fail++; $display("FAIL add_inf3 got %b want 0", bus.inf3); end
      if (bus.err  !== 1'b0) begin n_fail++; $display("FAIL add_err got %b want 0", bus.err); end
      if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL add_ready_in_done got %b want 1", bus.ready); end
      @(posedge clk); #1;
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse got %b want 0", bus.done); end
   endtask

   task automatic test_special;
      int lat;
      @(negedge clk);
      issue(1'b0, 1'b0, 5'd1, 5'd5, 1'b0, 5'd1, 5'd12);
      wait_done(lat);
      n_checks += 4;
      if (lat !== LSP) begin n_fail++; $display("FAIL opp_lat got %0d want %0d", lat, LSP); end
      if (bus.inf3 !== 1'b1) begin n_fail++; $display("FAIL opp_inf3 got %b want 1", bus.inf3); end
      if (bus.x3 !== 5'd0) begin n_fail++; $display("FAIL opp_x3 got %0d want 0", bus.x3); end
      if (bus.y3 !== 5'd0) begin n_fail++; $display("FAIL opp_y3 got %0d want 0", bus.y3); end
      @(negedge clk);
      issue(1'b0, 1'b1, 5'd3, 5'd3, 1'b0, 5'd2, 5'd10);
      wait_done(lat);
      n_checks += 4;
      if (lat !== LSP) begin n_fail++; $display("FAIL inf1_lat got %0d want %0d", lat, LSP); end
      if (bus.x3 !== 5'd2)  begin n_fail++; $display("FAIL inf1_x3 got %0d want 2", bus.x3); end
      if (bus.y3 !== 5'd10) begin n_fail++; $display("FAIL inf1_y3 got %0d want 10", bus.y3); end
      if (bus.inf3 !== 1'b0) begin n_fail++; $display("FAIL inf1_inf3 got %b want 0", bus.inf3); end
      @(negedge clk);
      issue(1'b0, 1'b0, 5'd5, 5'd8, 1'b1, 5'd0, 5'd0);
      wait_done(lat);
      n_checks += 3;
      if (lat !== LSP) begin n_fail++; $display("FAIL inf2_lat got %0d want %0d", lat, LSP); end
      if (bus.x3 !== 5'd5) begin n_fail++; $display("FAIL inf2_x3 got %0d want 5", bus.x3); end
      if (bus.y3 !== 5'd8) begin n_fail++; $display("FAIL inf2_y3 got %0d want 8", bus.y3); end
   endtask

   task automatic test_double;
      int lat;
      for (int m = 0; m < 2; m++) begin
         @(negedge clk);
         if (m == 0) issue(1'b1, 1'b0, 5'd2, 5'd7, 1'b0, 5'd9, 5'd9);
         else        issue(1'b0, 1'b0, 5'd2, 5'd7, 1'b0, 5'd2, 5'd7);
         wait_done(lat);
         n_checks += 5;
         if (lat !== DBL_LAT) begin n_fail++; $display("FAIL dbl%0d_lat got %0d want %0d", m, lat, DBL_LAT); end
         if (bus.x3 !== DBL_X) begin n_fail++; $display("FAIL dbl%0d_x3 got %0d want %0d", m, bus.x3, DBL_X); end
         if (bus.y3 !== DBL_Y) begin n_fail++; $display("FAIL dbl%0d_y3 got %0d want %0d", m, bus.y3, DBL_Y); end
         if (bus.inf3 !== DBL_INF) begin n_fail++; $display("FAIL dbl%0d_inf3 got %b want %b", m, bus.inf3, DBL_INF); end
         if (bus.err !== DBL_ERR) begin n_fail++; $display("FAIL dbl%0d_err got %b want %b", m, bus.err, DBL_ERR); end
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      @(negedge clk);
      issue(1'b0, 1'b0, 5'd1, 5'd5, 1'b0, 5'd2, 5'd7);
      lat = -1;
      for (int k = 1; k <= 400; k++) begin
         @(posedge clk); #1;
         if (k == 10) begin bus.op_dbl = 1'b1; bus.inf1 = 1'b1; bus.start = 1'b1; end
         if (k == 11) begin bus.start = 1'b0; bus.op_dbl = 1'b0; bus.inf1 = 1'b0; end
         if (bus.done === 1'b1) begin lat = k; break; end
      end
      n_checks += 4;
      if (lat !== LADD) begin n_fail++; $display("FAIL busy_lat got %0d want %0d", lat, LADD); end
      if (bus.x3 !== 5'd1)  begin n_fail++; $display("FAIL busy_x3 got %0d want 1", bus.x3); end
      if (bus.y3 !== 5'd12) begin n_fail++; $display("FAIL busy_y3 got %0d want 12", bus.y3); end
      if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", bus.ready); end
      issue(1'b0, 1'b0, 5'd1, 5'd5, 1'b0, 5'd5, 5'd8);
      wait_done(lat);
      n_checks += 4;
      if (lat !== LADD) begin n_fail++; $display("FAIL b2b_lat got %0d want %0d", lat, LADD); end
      if (bus.x3 !== 5'd2) begin n_fail++; $display("FAIL b2b_x3 got %0d want 2", bus.x3); end
      if (bus.y3 !== 5'd7) begin n_fail++; $display("FAIL b2b_y3 got %0d want 7", bus.y3); end
      if (bus.inf3 !== 1'b0) begin n_fail++; $display("FAIL b2b_inf3 got %b want 0", bus.inf3); end
   endtask

   task automatic test_reset_mid;
      int lat;
      int seen;
      @(negedge clk);
      issue(1'b0, 1'b0, 5'd1, 5'd5, 1'b0, 5'd2, 5'd7);
      repeat (29) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks += 5;
      if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got %b want 1", bus.ready); end
      if (bus.done  !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", bus.done); end
      if (bus.x3 !== 5'd0) begin n_fail++; $display("FAIL abort_x3 got %0d want 0", bus.x3); end
      if (bus.y3 !== 5'd0) begin n_fail++; $display("FAIL abort_y3 got %0d want 0", bus.y3); end
      if (bus.inf3 !== 1'b0) begin n_fail++; $display("FAIL abort_inf3 got %b want 0", bus.inf3); end
      seen = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) seen++;
      end
      n_checks += 1;
      if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", seen); end
      @(negedge clk);
      issue(1'b0, 1'b0, 5'd1, 5'd5, 1'b0, 5'd2, 5'd7);
      wait_done(lat);
      n_checks += 3;
      if (lat !== LADD) begin n_fail++; $display("FAIL post_rst_lat got %0d want %0d", lat, LADD); end
      if (bus.x3 !== 5'd1)  begin n_fail++; $display("FAIL post_rst_x3 got %0d want 1", bus.x3); end
      if (bus.y3 !== 5'd12) begin n_fail++; $display("FAIL post_rst_y3 got %0d want 12", bus.y3); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      clk = 1'b0;
      rst = 1'b1;
      bus.start = 1'b0; bus.op_dbl = 1'b0; bus.inf1 = 1'b0; bus.inf2 = 1'b0;
      bus.x1 = 5'd0; bus.y1 = 5'd0; bus.x2 = 5'd0; bus.y2 = 5'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      test_reset();
      test_add();
      test_special();
      test_double();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
